// File: rtl/xm_mem_arbiter.sv
// xm_mem_arbiter: shares one memory port between fetch (F) and data (D)
// requesters with round-robin grant, D bus lock, byte lanes and watchdog.
module xm_mem_arbiter #(
    parameter int WORD    = 16,
    parameter int ADR     = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            f_req_i,
    input  logic [ADR-1:0]  f_adr_i,
    output logic            f_ack_o,
    output logic            f_busy_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic            d_byte_i,
    input  logic            d_lock_i,
    input  logic [ADR-1:0]  d_adr_i,
    input  logic [WORD-1:0] d_wdata_i,
    output logic            d_ack_o,
    output logic            d_busy_o,
    output logic [WORD-1:0] rdata_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_be_o,
    output logic [ADR-1:0]  mem_adr_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [WORD-1:0] mem_rdata_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_q, last_d;
    logic            lock_q, lock_d;
    logic            lkreq_q, lkreq_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ADR-1:0]  adr_q, adr_d;
    logic            we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [WORD-1:0] rdata_q, rdata_d;

    logic f_ok;
    logic pick_d;
    logic d_mis;

    // gnt/last: 1 = D. While locked, F is invisible to the arbiter.
    assign f_ok   = f_req_i & ~lock_q;
    assign pick_d = d_req_i & (~f_ok | ~last_q);
    assign d_mis  = ~d_byte_i & d_adr_i[0];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        lock_d  = lock_q;
        lkreq_d = lkreq_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (f_ok | d_req_i) begin
                    gnt_d   = pick_d;
                    last_d  = pick_d;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (pick_d) begin
                        adr_d   = d_adr_i;
                        we_d    = d_we_i;
                        lkreq_d = d_lock_i;
                        err_d   = d_mis;
                        if (d_byte_i) begin
                            be_d    = d_adr_i[0] ? 2'b10 : 2'b01;
                            wdata_d = WORD'({d_wdata_i[7:0], d_wdata_i[7:0]});
                        end else begin
                            be_d    = 2'b11;
                            wdata_d = d_wdata_i;
                        end
                    end else begin
                        adr_d   = f_adr_i;
                        we_d    = 1'b0;
                        be_d    = 2'b11;
                        wdata_d = '0;
                        err_d   = f_adr_i[0];
                    end
                    state_d = err_d ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    // Byte reads return the addressed lane zero-extended
                    if (be_q == 2'b10) begin
                        rdata_d = WORD'(mem_rdata_i[15:8]);
                    end else if (be_q == 2'b01) begin
                        rdata_d = WORD'(mem_rdata_i[7:0]);
                    end else begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = S_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (gnt_q) begin
                    lock_d = lkreq_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
            lkreq_q <= 1'b0;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
            lkreq_q <= lkreq_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign f_ack_o     = (state_q == S_RESP) & ~gnt_q;
    assign d_ack_o     = (state_q == S_RESP) & gnt_q;
    assign err_o       = (state_q == S_RESP) & err_q;
    assign rdata_o     = (state_q == S_RESP) ? rdata_q : '0;
    assign f_busy_o    = f_req_i & ~f_ack_o;
    assign d_busy_o    = d_req_i & ~d_ack_o;
    assign mem_req_o   = (state_q == S_ACCESS);
    assign mem_we_o    = (state_q == S_ACCESS) & we_q;
    assign mem_be_o    = be_q;
    assign mem_adr_o   = adr_q;
    assign mem_wdata_o = wdata_q;

endmodule
